// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with PWM slots per digit, frame-synchronous
// double-buffered value/dp, blinking, leading-zero blanking and selectable polarity.
module seven_segment_scanner #(
   parameter int DIGITS           = 8,
   parameter int PWM_BITS         = 3,
   parameter int BLINK_BITS       = 6,
   parameter int ANODE_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 1
) (
   input  logic                  slow_clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     en_mask,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic                  blank_lz,
   input  logic [PWM_BITS-1:0]   brightness,
   input  logic                  update,
   output logic [DIGITS-1:0]     anodes,
   output logic [7:0]            segments,
   output logic                  frame_done
);

   localparam int                DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DW-1:0]     LAST_DIGIT = DW'(DIGITS - 1);
   localparam logic [PWM_BITS-1:0] SLOT_MAX = '1;
   localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{ANODE_ACTIVE_LOW != 0}};
   localparam logic [7:0]        SEG_OFF    = {8{SEG_ACTIVE_LOW != 0}};

   logic [PWM_BITS-1:0]   r_slot;
   logic [DW-1:0]         r_digit;
   logic [BLINK_BITS-1:0] r_blink;
   logic [4*DIGITS-1:0]   r_pend_val;
   logic [DIGITS-1:0]     r_pend_dp;
   logic                  r_pend_flag;
   logic [4*DIGITS-1:0]   r_shadow_val;
   logic [DIGITS-1:0]     r_shadow_dp;
   logic [DIGITS-1:0]     r_anodes;
   logic [7:0]            r_segments;
   logic                  r_frame_done;

   logic                  w_wrap;
   logic                  w_lit;
   logic [3:0]            w_nibble;
   logic [6:0]            w_code;
   logic [DIGITS-1:0]     w_lz;
   logic                  w_zero_run;
   logic [DIGITS-1:0]     w_onehot;
   logic [7:0]            w_seg_on;

   assign w_wrap   = (r_digit == LAST_DIGIT) && (r_slot == SLOT_MAX);
   assign w_nibble = r_shadow_val[{r_digit, 2'b00} +: 4];
   assign w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << r_digit;

   // Slot 0 of every digit stays dark so the previous digit's charge can drain.
   assign w_lit = en_mask[r_digit]
                  && (r_slot != '0)
                  && (r_slot <= brightness)
                  && !(blink_mask[r_digit] && r_blink[BLINK_BITS-1]);

   always_comb begin
      case (w_nibble)
         4'h0: w_code = 7'h3F;
         4'h1: w_code = 7'h06;
         4'h2: w_code = 7'h5B;
         4'h3: w_code = 7'h4F;
         4'h4: w_code = 7'h66;
         4'h5: w_code = 7'h6D;
         4'h6: w_code = 7'h7D;
         4'h7: w_code = 7'h07;
         4'h8: w_code = 7'h7F;
         4'h9: w_code = 7'h6F;
         4'hA: w_code = 7'h77;
         4'hB: w_code = 7'h7C;
         4'hC: w_code = 7'h39;
         4'hD: w_code = 7'h5E;
         4'hE: w_code = 7'h79;
         default: w_code = 7'h71;
      endcase
   end

   // Walk down from the top digit; a digit is blanked while every nibble so far is zero.
   always_comb begin
      w_lz       = '0;
      w_zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_run = w_zero_run && (r_shadow_val[4*i +: 4] == 4'h0);
         w_lz[i]    = blank_lz && w_zero_run;
      end
   end

   assign w_seg_on = {r_shadow_dp[r_digit], w_lz[r_digit] ? 7'h00 : w_code};

   always_ff @(posedge slow_clk) begin
      if (reset) begin
         r_slot       <= '0;
         r_digit      <= '0;
         r_blink      <= '0;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_flag  <= 1'b0;
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_anodes     <= AN_OFF;
         r_segments   <= SEG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_slot <= r_slot + 1'b1;
         if (r_slot == SLOT_MAX)
            r_digit <= (r_digit == LAST_DIGIT) ? '0 : r_digit + 1'b1;
         if (w_wrap)
            r_blink <= r_blink + 1'b1;

         if (update) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_mask;
         end
         // An update landing on the wrap cycle bypasses pending straight into shadow.
         if (w_wrap) begin
            r_pend_flag <= 1'b0;
            if (update) begin
               r_shadow_val <= value;
               r_shadow_dp  <= dp_mask;
            end else if (r_pend_flag) begin
               r_shadow_val <= r_pend_val;
               r_shadow_dp  <= r_pend_dp;
            end
         end else if (update) begin
            r_pend_flag <= 1'b1;
         end

         r_anodes     <= (w_lit ? w_onehot : '0) ^ AN_OFF;
         r_segments   <= (w_lit ? w_seg_on : 8'h00) ^ SEG_OFF;
         r_frame_done <= w_wrap;
      end
   end

   assign anodes     = r_anodes;
   assign segments   = r_segments;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (default parameters): per-frame
// scoreboard of expected slot occupancy and segment patterns per digit.
module tb_seven_segment_scanner;

   logic        slow_clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] value = '0;
   logic [7:0]  dp_mask = '0;
   logic [7:0]  en_mask = 8'hFF;
   logic [7:0]  blink_mask = '0;
   logic        blank_lz = 1'b0;
   logic [2:0]  brightness = 3'd7;
   logic        update = 1'b0;
   logic [7:0]  anodes;
   logic [7:0]  segments;
   logic        frame_done;

   seven_segment_scanner dut (
      .slow_clk   (slow_clk),
      .reset      (reset),
      .value      (value),
      .dp_mask    (dp_mask),
      .en_mask    (en_mask),
      .blink_mask (blink_mask),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .update     (update),
      .anodes     (anodes),
      .segments   (segments),
      .frame_done (frame_done)
   );

   always #5 slow_clk = ~slow_clk;

   typedef struct packed {
      logic [7:0][7:0] slots;
      logic [7:0][7:0] seg;
   } frame_t;

   frame_t      exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] cur_val = '0;
   logic [7:0]  cur_dp = '0;
   logic [6:0]  enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic step();
      @(posedge slow_clk);
      #1;
   endtask

   task automatic pulse_update(input logic [31:0] v, input logic [7:0] dp);
      value   = v;
      dp_mask = dp;
      update  = 1'b1;
      cur_val = v;
      cur_dp  = dp;
      step();
      update  = 1'b0;
   endtask

   function automatic frame_t model(input logic [31:0] v, input logic [7:0] dp,
                                    input bit blz, input int br, input logic [7:0] en);
      frame_t     f;
      logic [7:0] m;
      logic [7:0] hi;
      bit         blanked;
      for (int d = 0; d < 8; d++) begin
         m = '0;
         for (int s = 1; s < 8; s++)
            if (s <= br && en[d]) m[s] = 1'b1;
         blanked    = blz && (d > 0) && ((v >> (4*d)) == 32'h0);
         hi         = {dp[d], blanked ? 7'h00 : enc[v[4*d +: 4]]};
         f.slots[d] = m;
         f.seg[d]   = (m != 8'h0) ? ~hi : 8'hFF;
      end
      return f;
   endfunction

   // Records the 64 output cycles following the next (or current) frame_done pulse.
   task automatic capture_frame(output frame_t o, output int bad, output bit fd_ok);
      int         n = 0;
      int         d;
      int         s;
      logic [7:0] oh;
      o.slots = '0;
      o.seg   = {64{1'b1}};
      bad     = 0;
      fd_ok   = 1'b1;
      while (frame_done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         bad++;
         fd_ok = 1'b0;
      end
      for (int j = 0; j < 64; j++) begin
         step();
         d  = j / 8;
         s  = j % 8;
         oh = 8'h01 << d;
         if ((frame_done === 1'b1) != (j == 63)) fd_ok = 1'b0;
         if (anodes === 8'hFF) begin
            if (segments !== 8'hFF) bad++;
         end else if (anodes === ~oh) begin
            o.slots[d][s] = 1'b1;
            if (o.seg[d] !== 8'hFF && o.seg[d] !== segments) bad++;
            o.seg[d] = segments;
         end else begin
            bad++;
         end
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset = 1'b1;
      repeat (3) step();
      n_checks++;
      if (anodes !== 8'hFF) $display("FAIL reset_anodes got=%h exp=ff", anodes); else n_pass++;
      n_checks++;
      if (segments !== 8'hFF) $display("FAIL reset_segments got=%h exp=ff", segments); else n_pass++;
      n_checks++;
      if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else n_pass++;
      reset = 1'b0;
      while (frame_done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      n_checks++;
      if (n !== 64) $display("FAIL reset_first_frame_done got=%0d exp=64", n); else n_pass++;
   endtask

   task automatic test_basic();
      frame_t o, e;
      int     bad;
      bit     fd;
      pulse_update(32'h0000_0012, 8'h00);
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, brightness, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.slots !== e.slots) $display("FAIL basic_slots got=%h exp=%h", o.slots, e.slots); else n_pass++;
      n_checks++;
      if (o.seg !== e.seg) $display("FAIL basic_seg got=%h exp=%h", o.seg, e.seg); else n_pass++;
      n_checks++;
      if (bad !== 0) $display("FAIL basic_shape got=%0d exp=0", bad); else n_pass++;
      n_checks++;
      if (fd !== 1'b1) $display("FAIL basic_frame_period got=%b exp=1", fd); else n_pass++;
   endtask

   task automatic test_lz();
      frame_t o, e;
      int     bad;
      bit     fd;
      blank_lz = 1'b1;
      pulse_update(32'h0000_0105, 8'h10);
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, brightness, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg) $display("FAIL lz_seg got=%h exp=%h", o.seg, e.seg); else n_pass++;
      n_checks++;
      if (o.slots !== e.slots || bad !== 0) $display("FAIL lz_slots got=%h exp=%h bad=%0d", o.slots, e.slots, bad); else n_pass++;
      pulse_update(32'h0, 8'h00);
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, brightness, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg) $display("FAIL lz_zero_seg got=%h exp=%h", o.seg, e.seg); else n_pass++;
      blank_lz = 1'b0;
   endtask

   task automatic test_back_to_back();
      frame_t o, e;
      int     bad;
      bit     fd;
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, brightness, en_mask));
      fork
         capture_frame(o, bad, fd);
         begin
            repeat (10) step();
            pulse_update(32'h1111_1111, 8'h00);
            step();
            pulse_update(32'h2222_2222, 8'h00);
         end
      join
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg || bad !== 0) $display("FAIL b2b_current_frame got=%h exp=%h bad=%0d", o.seg, e.seg, bad); else n_pass++;
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, brightness, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg || bad !== 0) $display("FAIL b2b_next_frame got=%h exp=%h bad=%0d", o.seg, e.seg, bad); else n_pass++;
   endtask

   task automatic test_wrap_bypass();
      frame_t o, e;
      int     bad;
      bit     fd;
      repeat (63) step();
      exp_q.push_back(model(32'hAAAA_AAAA, 8'h00, blank_lz, brightness, en_mask));
      pulse_update(32'hAAAA_AAAA, 8'h00);
      n_checks++;
      if (frame_done !== 1'b1) $display("FAIL bypass_alignment got=%b exp=1", frame_done); else n_pass++;
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg || bad !== 0) $display("FAIL bypass_frame got=%h exp=%h bad=%0d", o.seg, e.seg, bad); else n_pass++;
   endtask

   task automatic test_brightness();
      frame_t o, e;
      int     bad;
      bit     fd;
      brightness = 3'd0;
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, 0, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.slots !== e.slots || bad !== 0) $display("FAIL bright0_slots got=%h exp=%h bad=%0d", o.slots, e.slots, bad); else n_pass++;
      brightness = 3'd3;
      en_mask    = 8'hFB;
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, 3, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.slots !== e.slots) $display("FAIL bright3_slots got=%h exp=%h", o.slots, e.slots); else n_pass++;
      n_checks++;
      if (o.seg !== e.seg || bad !== 0) $display("FAIL bright3_seg got=%h exp=%h bad=%0d", o.seg, e.seg, bad); else n_pass++;
      brightness = 3'd7;
      en_mask    = 8'hFF;
   endtask

   task automatic test_reset_mid();
      frame_t     o, e;
      int         bad;
      bit         fd;
      int         n = 0;
      logic [7:0] first_an = 8'hFF;
      pulse_update(32'h4444_4444, 8'h00);
      exp_q.push_back(model(cur_val, cur_dp, blank_lz, brightness, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg) $display("FAIL rstmid_before got=%h exp=%h", o.seg, e.seg); else n_pass++;
      repeat (5) step();
      pulse_update(32'h9999_9999, 8'h00);
      repeat (36) step();
      reset = 1'b1;
      step();
      n_checks++;
      if (anodes !== 8'hFF || segments !== 8'hFF || frame_done !== 1'b0)
         $display("FAIL rstmid_outputs got=%h/%h/%b exp=ff/ff/0", anodes, segments, frame_done);
      else n_pass++;
      reset = 1'b0;
      while (frame_done !== 1'b1 && n < 200) begin
         step();
         n++;
         if (first_an === 8'hFF && anodes !== 8'hFF) first_an = anodes;
      end
      n_checks++;
      if (n !== 64) $display("FAIL rstmid_frame_len got=%0d exp=64", n); else n_pass++;
      n_checks++;
      if (first_an !== 8'hFE) $display("FAIL rstmid_first_digit got=%h exp=fe", first_an); else n_pass++;
      exp_q.push_back(model(32'h0, 8'h00, blank_lz, brightness, en_mask));
      capture_frame(o, bad, fd);
      e = exp_q.pop_front();
      n_checks++;
      if (o.seg !== e.seg || bad !== 0) $display("FAIL rstmid_pending_dropped got=%h exp=%h bad=%0d", o.seg, e.seg, bad); else n_pass++;
   endtask

   task automatic test_blink();
      frame_t o;
      int     bad;
      bit     fd;
      int     lit0 = 0;
      int     lit1 = 0;
      int     first_dark = -1;
      int     bad_total = 0;
      reset = 1'b1;
      repeat (2) step();
      reset      = 1'b0;
      blink_mask = 8'h01;
      for (int f = 0; f < 64; f++) begin
         capture_frame(o, bad, fd);
         bad_total += bad;
         if (o.slots[0] != 8'h0) lit0++;
         else if (first_dark < 0) first_dark = f;
         if (o.slots[1] != 8'h0) lit1++;
      end
      n_checks++;
      if (lit0 !== 32) $display("FAIL blink_lit_frames got=%0d exp=32", lit0); else n_pass++;
      n_checks++;
      if (first_dark !== 31) $display("FAIL blink_first_dark got=%0d exp=31", first_dark); else n_pass++;
      n_checks++;
      if (lit1 !== 64 || bad_total !== 0) $display("FAIL blink_other_digit got=%0d exp=64 bad=%0d", lit1, bad_total); else n_pass++;
      blink_mask = 8'h00;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lz();
      test_back_to_back();
      test_wrap_bypass();
      test_brightness();
      test_reset_mid();
      test_blink();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
